// File: rtl/control_pipe_pkg.sv
// Shared definitions for the decoded-control pipeline: control-bundle bit
// positions, pc/forwarding select encodings and the bubble value.
package control_pipe_pkg;

   localparam int CTRL_W = 11;

   // {regDst, branch_eq, branch_ne, memRead, memWrite, memToReg, regWrite, aluSrc, jump, aluOp[1:0]}
   localparam int CTRL_REGDST   = 10;
   localparam int CTRL_BEQ      = 9;
   localparam int CTRL_BNE      = 8;
   localparam int CTRL_MEMREAD  = 7;
   localparam int CTRL_MEMWRITE = 6;
   localparam int CTRL_MEMTOREG = 5;
   localparam int CTRL_REGWRITE = 4;
   localparam int CTRL_ALUSRC   = 3;
   localparam int CTRL_JUMP     = 2;
   localparam int CTRL_ALUOP    = 0;

   localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
   localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b10;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   localparam logic [CTRL_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/control_pipe_fwd_unit.sv
// Forwarding select for one ALU operand; the younger EX/MEM result wins over
// MEM/WB, and register 0 is never forwarded.
module fwd_unit
   import control_pipe_pkg::*;
#(
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] src,
   input  logic            mem_regwrite,
   input  logic [RA_W-1:0] mem_wreg,
   input  logic            wb_regwrite,
   input  logic [RA_W-1:0] wb_wreg,
   output logic [1:0]      sel
);

   always_comb begin
      sel = FWD_RF;
      if (mem_regwrite && (mem_wreg != '0) && (mem_wreg == src))
         sel = FWD_EXMEM;
      else if (wb_regwrite && (wb_wreg != '0) && (wb_wreg == src))
         sel = FWD_MEMWB;
   end

endmodule

// File: rtl/control_pipe.sv
// Control side of the 5-stage pipeline: ID/EX, EX/MEM, MEM/WB control stage
// registers, branch/jump/load-use hazard resolution, forwarding and counters.
module control_pipe
   import control_pipe_pkg::*;
#(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic [RA_W-1:0]   id_rd,
   input  logic              ex_zero,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [3:0]        mem_ctrl,
   output logic [1:0]        wb_ctrl,
   output logic [RA_W-1:0]   ex_rs,
   output logic [RA_W-1:0]   ex_rt,
   output logic [RA_W-1:0]   ex_wreg,
   output logic [RA_W-1:0]   mem_wreg,
   output logic [RA_W-1:0]   wb_wreg,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic [1:0]        pc_sel,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic              mem_regwrite;
   logic              mem_memtoreg;
   logic              taken;
   logic              stall;
   logic              jump;
   logic [CTRL_W-1:0] idex_ctrl_d;
   logic [RA_W-1:0]   idex_wreg_d;
   logic [RA_W-1:0]   idex_rs_d;
   logic [RA_W-1:0]   idex_rt_d;

   // Branch outranks everything; stall already excludes jumps in ID.
   always_comb begin
      taken = (ex_ctrl[CTRL_BEQ] & ex_zero) | (ex_ctrl[CTRL_BNE] & ~ex_zero);
      stall = ex_ctrl[CTRL_MEMREAD] && (ex_wreg != '0)
              && ((ex_wreg == id_rs) || (ex_wreg == id_rt))
              && !id_ctrl[CTRL_JUMP] && !taken;
      jump  = id_ctrl[CTRL_JUMP] & ~taken;
   end

   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      pc_sel     = PC_SEL_SEQ;
      if (taken) begin
         pc_sel     = PC_SEL_BRANCH;
         ifid_flush = 1'b1;
      end else if (stall) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (jump) begin
         pc_sel     = PC_SEL_JUMP;
         ifid_flush = 1'b1;
      end
   end

   always_comb begin
      idex_ctrl_d = id_ctrl;
      idex_wreg_d = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
      idex_rs_d   = id_rs;
      idex_rt_d   = id_rt;
      if (jump)
         idex_ctrl_d[CTRL_REGWRITE] = 1'b0;
      if (taken || stall) begin
         idex_ctrl_d = BUBBLE;
         idex_wreg_d = '0;
         idex_rs_d   = '0;
         idex_rt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_ctrl      <= BUBBLE;
         ex_wreg      <= '0;
         ex_rs        <= '0;
         ex_rt        <= '0;
         mem_ctrl     <= '0;
         mem_regwrite <= 1'b0;
         mem_memtoreg <= 1'b0;
         mem_wreg     <= '0;
         wb_ctrl      <= '0;
         wb_wreg      <= '0;
         stall_cnt    <= '0;
         flush_cnt    <= '0;
      end else begin
         ex_ctrl      <= idex_ctrl_d;
         ex_wreg      <= idex_wreg_d;
         ex_rs        <= idex_rs_d;
         ex_rt        <= idex_rt_d;
         mem_ctrl     <= {ex_ctrl[CTRL_BEQ], ex_ctrl[CTRL_BNE],
                          ex_ctrl[CTRL_MEMREAD], ex_ctrl[CTRL_MEMWRITE]};
         mem_regwrite <= ex_ctrl[CTRL_REGWRITE];
         mem_memtoreg <= ex_ctrl[CTRL_MEMTOREG];
         mem_wreg     <= ex_wreg;
         wb_ctrl      <= {mem_memtoreg, mem_regwrite};
         wb_wreg      <= mem_wreg;
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (ifid_flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   fwd_unit #(.RA_W(RA_W)) u_fwd_a (
      .src          (ex_rs),
      .mem_regwrite (mem_regwrite),
      .mem_wreg     (mem_wreg),
      .wb_regwrite  (wb_ctrl[0]),
      .wb_wreg      (wb_wreg),
      .sel          (fwd_a)
   );

   fwd_unit #(.RA_W(RA_W)) u_fwd_b (
      .src          (ex_rt),
      .mem_regwrite (mem_regwrite),
      .mem_wreg     (mem_wreg),
      .wb_regwrite  (wb_ctrl[0]),
      .wb_wreg      (wb_wreg),
      .sel          (fwd_b)
   );

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: expectations are queued as stimulus is
// driven and popped against the DUT outputs mid-cycle.
module tb_control_pipe;
   import control_pipe_pkg::*;

   localparam int RA_W  = 5;
   localparam int CNT_W = 4;

   localparam logic [10:0] C_NOP = 11'h000;
   localparam logic [10:0] C_LW  = 11'h0B8;
   localparam logic [10:0] C_ADD = 11'h412;
   localparam logic [10:0] C_BEQ = 11'h201;
   localparam logic [10:0] C_J   = 11'h004;
   localparam logic [10:0] C_JAL = 11'h014;

   logic              clk = 1'b0;
   logic              rst;
   logic [10:0]       id_ctrl;
   logic [RA_W-1:0]   id_rs, id_rt, id_rd;
   logic              ex_zero;
   logic [10:0]       ex_ctrl;
   logic [3:0]        mem_ctrl;
   logic [1:0]        wb_ctrl;
   logic [RA_W-1:0]   ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
   logic              pc_write, ifid_write, ifid_flush;
   logic [1:0]        pc_sel, fwd_a, fwd_b;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   control_pipe #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_ctrl    (id_ctrl),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rd      (id_rd),
      .ex_zero    (ex_zero),
      .ex_ctrl    (ex_ctrl),
      .mem_ctrl   (mem_ctrl),
      .wb_ctrl    (wb_ctrl),
      .ex_rs      (ex_rs),
      .ex_rt      (ex_rt),
      .ex_wreg    (ex_wreg),
      .mem_wreg   (mem_wreg),
      .wb_wreg    (wb_wreg),
      .pc_write   (pc_write),
      .ifid_write (ifid_write),
      .ifid_flush (ifid_flush),
      .pc_sel     (pc_sel),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   typedef enum int {
      S_EX_CTRL, S_MEM_CTRL, S_WB_CTRL, S_EX_WREG, S_MEM_WREG, S_WB_WREG,
      S_PC_WRITE, S_IFID_WRITE, S_IFID_FLUSH, S_PC_SEL, S_FWD_A, S_FWD_B,
      S_STALL_CNT, S_FLUSH_CNT
   } sig_e;

   typedef struct {
      string       tag;
      sig_e        sig;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] sample(input sig_e s);
      case (s)
         S_EX_CTRL:    return 32'(ex_ctrl);
         S_MEM_CTRL:   return 32'(mem_ctrl);
         S_WB_CTRL:    return 32'(wb_ctrl);
         S_EX_WREG:    return 32'(ex_wreg);
         S_MEM_WREG:   return 32'(mem_wreg);
         S_WB_WREG:    return 32'(wb_wreg);
         S_PC_WRITE:   return 32'(pc_write);
         S_IFID_WRITE: return 32'(ifid_write);
         S_IFID_FLUSH: return 32'(ifid_flush);
         S_PC_SEL:     return 32'(pc_sel);
         S_FWD_A:      return 32'(fwd_a);
         S_FWD_B:      return 32'(fwd_b);
         S_STALL_CNT:  return 32'(stall_cnt);
         default:      return 32'(flush_cnt);
      endcase
   endfunction

   task automatic push_exp(input string tag, input sig_e s, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sig = s;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [10:0] c, input logic [RA_W-1:0] rs,
                        input logic [RA_W-1:0] rt, input logic [RA_W-1:0] rd,
                        input logic z);
      id_ctrl = c;
      id_rs   = rs;
      id_rt   = rt;
      id_rd   = rd;
      ex_zero = z;
   endtask

   // Let inputs settle, compare everything queued for this cycle, then advance.
   task automatic cyc();
      exp_t e;
      #2;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_val(e.tag, sample(e.sig), e.exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drive(C_NOP, 0, 0, 0, 1'b0);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      rst = 1'b1;
      drive(C_LW, 5'd3, 5'd8, 5'd0, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;

      push_exp("rst_ex_ctrl",  S_EX_CTRL,   0);
      push_exp("rst_mem_ctrl", S_MEM_CTRL,  0);
      push_exp("rst_wb_ctrl",  S_WB_CTRL,   0);
      push_exp("rst_ex_wreg",  S_EX_WREG,   0);
      push_exp("rst_pc_write", S_PC_WRITE,  1);
      push_exp("rst_ifid_wr",  S_IFID_WRITE,1);
      push_exp("rst_flush",    S_IFID_FLUSH,0);
      push_exp("rst_pc_sel",   S_PC_SEL,    0);
      push_exp("rst_fwd_a",    S_FWD_A,     0);
      push_exp("rst_fwd_b",    S_FWD_B,     0);
      push_exp("rst_stall",    S_STALL_CNT, 0);
      push_exp("rst_fcnt",     S_FLUSH_CNT, 0);
      cyc();
      rst = 1'b0;
      idle(3);

      // load-use: lw $8 then add using $8 as rs
      drive(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
      push_exp("lu_lw_pcw", S_PC_WRITE, 1);
      cyc();
      drive(C_ADD, 5'd8, 5'd2, 5'd3, 1'b0);
      push_exp("lu_ex_lw",    S_EX_CTRL,    C_LW);
      push_exp("lu_ex_wreg",  S_EX_WREG,    8);
      push_exp("lu_pcw0",     S_PC_WRITE,   0);
      push_exp("lu_ifidw0",   S_IFID_WRITE, 0);
      push_exp("lu_noflush",  S_IFID_FLUSH, 0);
      push_exp("lu_pcsel",    S_PC_SEL,     0);
      cyc();
      push_exp("lu_bubble",   S_EX_CTRL,    0);
      push_exp("lu_bub_wreg", S_EX_WREG,    0);
      push_exp("lu_mem_ctrl", S_MEM_CTRL,   4'b0010);
      push_exp("lu_mem_wreg", S_MEM_WREG,   8);
      push_exp("lu_pcw1",     S_PC_WRITE,   1);
      push_exp("lu_stall1",   S_STALL_CNT,  1);
      cyc();
      drive(C_NOP, 0, 0, 0, 1'b0);
      push_exp("lu_ex_add",   S_EX_CTRL,    C_ADD);
      push_exp("lu_add_wreg", S_EX_WREG,    3);
      push_exp("lu_wb_ctrl",  S_WB_CTRL,    2'b11);
      push_exp("lu_wb_wreg",  S_WB_WREG,    8);
      push_exp("lu_fwd_a",    S_FWD_A,      2'b01);
      push_exp("lu_fwd_b",    S_FWD_B,      2'b00);
      push_exp("lu_stall_k",  S_STALL_CNT,  1);
      cyc();
      idle(3);

      // back-to-back: two writers of $9, reader uses $9 on both operands
      drive(C_ADD, 5'd1, 5'd2, 5'd9, 1'b0);
      cyc();
      drive(C_ADD, 5'd4, 5'd5, 5'd9, 1'b0);
      cyc();
      drive(C_ADD, 5'd9, 5'd9, 5'd10, 1'b0);
      cyc();
      drive(C_NOP, 0, 0, 0, 1'b0);
      push_exp("b2b_fwd_a", S_FWD_A, 2'b10);
      push_exp("b2b_fwd_b", S_FWD_B, 2'b10);
      cyc();
      idle(3);

      // MEM/WB-only forwarding, operand b only
      drive(C_ADD, 5'd1, 5'd2, 5'd12, 1'b0);
      cyc();
      drive(C_NOP, 0, 0, 0, 1'b0);
      cyc();
      drive(C_ADD, 5'd7, 5'd12, 5'd13, 1'b0);
      cyc();
      drive(C_NOP, 0, 0, 0, 1'b0);
      push_exp("wb_fwd_a", S_FWD_A, 2'b00);
      push_exp("wb_fwd_b", S_FWD_B, 2'b01);
      cyc();
      idle(3);

      // a write of $0 is never forwarded
      drive(C_ADD, 5'd1, 5'd2, 5'd0, 1'b0);
      cyc();
      drive(C_ADD, 5'd0, 5'd0, 5'd11, 1'b0);
      cyc();
      drive(C_NOP, 0, 0, 0, 1'b0);
      push_exp("r0_fwd_a", S_FWD_A, 2'b00);
      push_exp("r0_fwd_b", S_FWD_B, 2'b00);
      cyc();
      idle(3);

      // taken beq in EX with a jump in ID
      drive(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
      cyc();
      drive(C_J, 5'd0, 5'd0, 5'd0, 1'b1);
      push_exp("br_pc_sel", S_PC_SEL,     2'b10);
      push_exp("br_flush",  S_IFID_FLUSH, 1);
      push_exp("br_pcw",    S_PC_WRITE,   1);
      push_exp("br_fcnt0",  S_FLUSH_CNT,  0);
      cyc();
      drive(C_NOP, 0, 0, 0, 1'b0);
      push_exp("br_bubble", S_EX_CTRL,    0);
      push_exp("br_fcnt1",  S_FLUSH_CNT,  1);
      push_exp("br_pcsel0", S_PC_SEL,     0);
      cyc();
      idle(2);

      // not-taken beq
      drive(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
      cyc();
      push_exp("nt_pc_sel", S_PC_SEL,     0);
      push_exp("nt_flush",  S_IFID_FLUSH, 0);
      cyc();
      push_exp("nt_fcnt",   S_FLUSH_CNT,  1);
      cyc();
      idle(2);

      // jump alone, carrying a regWrite that must be dropped
      drive(C_JAL, 5'd0, 5'd0, 5'd0, 1'b0);
      push_exp("j_pc_sel", S_PC_SEL,     2'b01);
      push_exp("j_flush",  S_IFID_FLUSH, 1);
      cyc();
      drive(C_NOP, 0, 0, 0, 1'b0);
      push_exp("j_ex_ctrl", S_EX_CTRL,   C_J);
      push_exp("j_pcsel0",  S_PC_SEL,    0);
      push_exp("j_fcnt",    S_FLUSH_CNT, 2);
      cyc();
      idle(2);

      // jump whose rs matches a pending load: no stall
      drive(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
      cyc();
      drive(C_J, 5'd8, 5'd8, 5'd0, 1'b0);
      push_exp("jl_pcw",    S_PC_WRITE, 1);
      push_exp("jl_ifidw",  S_IFID_WRITE, 1);
      push_exp("jl_pc_sel", S_PC_SEL,   2'b01);
      cyc();
      drive(C_NOP, 0, 0, 0, 1'b0);
      push_exp("jl_stall",  S_STALL_CNT, 1);
      push_exp("jl_fcnt",   S_FLUSH_CNT, 3);
      cyc();
      idle(2);

      // flush every cycle for 2^CNT_W + 5 cycles
      drive(C_J, 5'd0, 5'd0, 5'd0, 1'b0);
      for (int i = 0; i < (1 << CNT_W) + 5; i++) cyc();
      drive(C_NOP, 0, 0, 0, 1'b0);
      push_exp("sat_fcnt",  S_FLUSH_CNT, 4'hF);
      cyc();
      push_exp("sat_hold",  S_FLUSH_CNT, 4'hF);
      cyc();

      // reset mid-operation with a hazard pending
      drive(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
      cyc();
      drive(C_ADD, 5'd8, 5'd2, 5'd3, 1'b0);
      rst = 1'b1;
      cyc();
      push_exp("mr_ex_ctrl", S_EX_CTRL,   0);
      push_exp("mr_mem",     S_MEM_CTRL,  0);
      push_exp("mr_pcw",     S_PC_WRITE,  1);
      push_exp("mr_stall",   S_STALL_CNT, 0);
      push_exp("mr_fcnt",    S_FLUSH_CNT, 0);
      cyc();
      rst = 1'b0;
      idle(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Receiving end of the decoded-control interface in the 5-stage MIPS pipeline.
- Takes the per-instruction control bundle from the ID-stage decoder and carries it through the ID/EX, EX/MEM and MEM/WB stage registers.
- Detects load-use hazards and resolves branches (in EX) and jumps (in ID). Drives stall, flush and forwarding selects.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- RA_W, 5, register-address width.
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_ctrl  in  11  {regDst, branch_eq, branch_ne, memRead, memWrite, memToReg, regWrite, aluSrc, jump, aluOp[1:0]} from the decoder.
- id_rs, id_rt, id_rd  in  RA_W  register fields of the instruction in ID.
- ex_zero  in  1  ALU zero flag for the instruction currently in EX.
- ex_ctrl  out  11  ID/EX control register.
- mem_ctrl  out  4  {branch_eq, branch_ne, memRead, memWrite}; only branch and memory bits advance past EX.
- wb_ctrl  out  2  {memToReg, regWrite}, MEM/WB copy.
- ex_rs, ex_rt  out  RA_W  ID/EX copies of the source fields.
- ex_wreg, mem_wreg, wb_wreg  out  RA_W  destination register per stage.
- pc_write  out  1  0 = hold the PC.
- ifid_write  out  1  0 = hold IF/ID.
- ifid_flush  out  1  1 = zero IF/ID.
- pc_sel  out  2  00 = PC+4, 01 = jump target, 10 = branch target.
- fwd_a, fwd_b  out  2  ALU operand source: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- stall_cnt, flush_cnt  out  CNT_W  event counters.

Behaviour:
- Reset: every stage control register, wreg field and counter is 0 (bubbles). With empty stages the combinational outputs evaluate to:
  - pc_write = 1, ifid_write = 1, ifid_flush = 0
  - pc_sel = 00, fwd_a = fwd_b = 00
- Reset mid-operation discards all in-flight control. There is no partial drain.
- Destination select in ID/EX: ex_wreg = regDst ? rd : rt.
- EX/MEM and MEM/WB wreg and control fields advance unconditionally every cycle.
- Branch taken (combinational, EX stage): taken = ex_ctrl.branch_eq & ex_zero | ex_ctrl.branch_ne & ~ex_zero.
  - pc_sel = 10, ifid_flush = 1.
  - ID/EX loads a bubble (all-zero control, wreg 0) on the next edge.
  - Result: two-instruction penalty.
- Jump (ID stage, no branch taken): pc_sel = 01, ifid_flush = 1.
  - The jump itself advances into ID/EX with regWrite = 0 and becomes a bubble downstream.
  - Result: one-instruction penalty.
- Load-use stall: ex_ctrl.memRead & ex_wreg != 0 & (ex_wreg == id_rs | ex_wreg == id_rt) & ~id_ctrl.jump.
  - pc_write = 0, ifid_write = 0.
  - ID/EX loads a bubble.
  - Exactly one stall cycle per hazard, because the load moves to MEM on the next cycle.
- Priority, highest first:
  1. Branch taken. It suppresses the stall and the jump in the same cycle. pc_write stays 1 and neither counter double-counts.
  2. Load-use stall.
  3. Jump.
- Forwarding for fwd_a uses ex_rs; fwd_b uses ex_rt with the same rules.
  - Select 10 when mem regWrite & mem_wreg != 0 & mem_wreg == src.
  - Otherwise select 01 when wb_ctrl.regWrite & wb_wreg != 0 & wb_wreg == src.
  - Otherwise select 00. EX/MEM always beats MEM/WB.
  - Register 0 is never forwarded.
  - A regWrite copy is kept in EX/MEM internally for this purpose.
- Counters:
  - stall_cnt increments on each load-use stall cycle.
  - flush_cnt increments on each cycle with ifid_flush = 1.
  - Both saturate at all-ones and never wrap.
- All hazard and forwarding outputs are combinational from stage registers and ID inputs. Latency is 0 cycles; stage registers add 1 cycle per stage.

Decomposition:
- Shared package contents:
  - control-bundle bit-index constants (CTRL_REGDST .. CTRL_ALUOP)
  - the control width of 11
  - pc_sel encodings
  - fwd encodings
  - the BUBBLE constant (all zeros)
- Sub-module fwd_unit: pure combinational forwarding compare, instantiated twice (A and B).
- Stage registers, hazard priority logic and counters stay in control_pipe.

Test Plan:
- Reset: assert rst 2 cycles with nonzero id_ctrl -> all stage ctrl = 0, pc_write = 1, fwd = 00, counters = 0.
- Load-use: lw with rt = 8, then add with rs = 8 -> exactly 1 cycle with pc_write = 0, ex_ctrl = 0; on the next cycle fwd_a = 01; stall_cnt = 1.
- Back-to-back ALU ops: add $9, then add $10, $9, $9 -> fwd_a = fwd_b = 10 in EX. A write of $0 gives fwd = 00.
- beq in EX with ex_zero = 1 and a jump in ID in the same cycle -> pc_sel = 10 (not 01), ifid_flush = 1, next ex_ctrl = 0, flush_cnt += 1. With ex_zero = 0 -> pc_sel = 00.
- Jump alone -> pc_sel = 01 for 1 cycle, ifid_flush = 1; the ID/EX copy of the jump has regWrite = 0. A jump whose rs field matches a pending lw destination -> no stall.
- Saturation: force flush every cycle for 2^CNT_W + 5 cycles (CNT_W = 4 override) -> flush_cnt holds 4'hF.
